dmem_test_monitor: RTL and testbench

- Parametrised, synthesizable end-of-test monitor for CPU_Core programs. Replaces fixed-length "run N cycles then stop" benches.
- Snoops the data-memory write bus, logs stores that fall into a signature window, and checks the logged values against an internally generated Fibonacci sequence when enabled.
- Ends the run on a mailbox store or on a cycle timeout, and reports pass, fail or timeout plus the cycle count.
- Sits beside the RAM on the DMEM bus, both in benches and on FPGA builds.

---
 rtl/dmem_test_monitor.sv | 150 +++++++++++++++
 tb/tb_dmem_test_monitor.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_test_monitor.sv
// End-of-test monitor for CPU_Core programs on the DMEM write bus.
// Logs stores that land in the signature window and optionally checks each one
// against a running Fibonacci sequence. The run ends on a mailbox store or when
// the cycle limit is reached.
module dmem_test_monitor #(
  parameter int                ADDR_W       = 10,
  parameter int                DATA_W       = 32,
  parameter logic [ADDR_W-1:0] SIG_BASE     = 10'h100,
  parameter int                SIG_DEPTH    = 16,
  parameter logic [ADDR_W-1:0] MAILBOX_ADDR = 10'h3FF,
  parameter int                TIMEOUT      = 3000,
  parameter int                CNT_W        = 32,
  parameter bit                CHECK_FIB    = 1'b1,
  localparam int               IDX_W        = $clog2(SIG_DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] address_DMEM,
  input  logic [DATA_W-1:0] write_data_DMEM,
  input  logic [IDX_W-1:0]  sig_rd_idx,
  output logic [DATA_W-1:0] sig_rd_data,
  output logic [IDX_W:0]    sig_count,
  output logic [CNT_W-1:0]  cycles,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [DATA_W-1:0] exit_code,
  output logic              mismatch,
  output logic [IDX_W-1:0]  first_bad_idx,
  output logic              overflow
);

  localparam logic [ADDR_W:0]  SIG_END = {1'b0, SIG_BASE} + (ADDR_W+1)'(SIG_DEPTH);
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
  localparam logic [IDX_W:0]   FULL    = (IDX_W+1)'(SIG_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] log_q [SIG_DEPTH];
  logic [DATA_W-1:0] fib_a_q, fib_b_q;
  logic [IDX_W:0]    sig_count_q;
  logic [CNT_W-1:0]  cycles_q;
  logic              busy_q, done_q, pass_q, timeout_q, mismatch_q, overflow_q;
  logic [DATA_W-1:0] exit_code_q;
  logic [IDX_W-1:0]  first_bad_q;

  logic             win_hit, mbox_hit, log_full, fib_bad;
  logic [CNT_W-1:0] cyc_inc;

  // Address decode; the window bound is computed one bit wider so a window
  // ending at the top of the address space does not wrap.
  assign win_hit  = MemWrite && ({1'b0, address_DMEM} >= {1'b0, SIG_BASE}) &&
                    ({1'b0, address_DMEM} < SIG_END);
  assign mbox_hit = MemWrite && (address_DMEM == MAILBOX_ADDR);
  assign log_full = (sig_count_q == FULL);
  assign fib_bad  = CHECK_FIB && (write_data_DMEM != fib_a_q);
  assign cyc_inc  = cycles_q + CNT_W'(1);

  // Run-control FSM plus log, checker and all registered status outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      fib_a_q     <= '0;
      fib_b_q     <= DATA_W'(1);
      sig_count_q <= '0;
      cycles_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      mismatch_q  <= 1'b0;
      overflow_q  <= 1'b0;
      exit_code_q <= '0;
      first_bad_q <= '0;
      for (int i = 0; i < SIG_DEPTH; i++) log_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          // Bus traffic in the start cycle is deliberately dropped.
          if (start) begin
            state_q     <= S_RUN;
            fib_a_q     <= '0;
            fib_b_q     <= DATA_W'(1);
            sig_count_q <= '0;
            cycles_q    <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            mismatch_q  <= 1'b0;
            overflow_q  <= 1'b0;
            exit_code_q <= '0;
            first_bad_q <= '0;
            for (int i = 0; i < SIG_DEPTH; i++) log_q[i] <= '0;
          end
        end
        S_RUN: begin
          cycles_q <= cyc_inc;
          // Window stores append in arrival order; the address only qualifies.
          if (win_hit) begin
            if (!log_full) begin
              log_q[sig_count_q[IDX_W-1:0]] <= write_data_DMEM;
              sig_count_q <= sig_count_q + (IDX_W+1)'(1);
              if (fib_bad && !mismatch_q) begin
                mismatch_q  <= 1'b1;
                first_bad_q <= sig_count_q[IDX_W-1:0];
              end
              fib_a_q <= fib_b_q;
              fib_b_q <= fib_a_q + fib_b_q;
            end else begin
              overflow_q <= 1'b1;
            end
          end
          // Mailbox takes priority over a timeout landing on the same cycle.
          if (mbox_hit) begin
            exit_code_q <= write_data_DMEM;
            pass_q      <= (write_data_DMEM == DATA_W'(1)) && !mismatch_q && !overflow_q;
            state_q     <= S_DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end else if (cyc_inc == TMO) begin
            timeout_q <= 1'b1;
            pass_q    <= 1'b0;
            state_q   <= S_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sig_rd_data   = log_q[sig_rd_idx];
  assign sig_count     = sig_count_q;
  assign cycles        = cycles_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign timeout       = timeout_q;
  assign exit_code     = exit_code_q;
  assign mismatch      = mismatch_q;
  assign first_bad_idx = first_bad_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_dmem_test_monitor.sv
// Directed bench for dmem_test_monitor with default parameters.
module tb_dmem_test_monitor;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic        MemWrite = 1'b0;
  logic [9:0]  address_DMEM = '0;
  logic [31:0] write_data_DMEM = '0;
  logic [3:0]  sig_rd_idx = '0;
  logic [31:0] sig_rd_data;
  logic [4:0]  sig_count;
  logic [31:0] cycles;
  logic        busy, done, pass, timeout, mismatch, overflow;
  logic [31:0] exit_code;
  logic [3:0]  first_bad_idx;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_test_monitor dut (
    .CLK(CLK), .RST(RST), .start(start), .MemWrite(MemWrite),
    .address_DMEM(address_DMEM), .write_data_DMEM(write_data_DMEM),
    .sig_rd_idx(sig_rd_idx), .sig_rd_data(sig_rd_data), .sig_count(sig_count),
    .cycles(cycles), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .exit_code(exit_code), .mismatch(mismatch), .first_bad_idx(first_bad_idx),
    .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic store(input logic [9:0] a, input logic [31:0] d);
    MemWrite = 1'b1;
    address_DMEM = a;
    write_data_DMEM = d;
    tick();
    MemWrite = 1'b0;
  endtask

  task automatic rd(input int idx, output logic [31:0] v);
    sig_rd_idx = 4'(idx);
    #1;
    v = sig_rd_data;
  endtask

  int fibs [8] = '{0, 1, 1, 2, 3, 5, 8, 13};
  int bads [8] = '{0, 1, 1, 2, 3, 9, 8, 13};

  initial begin
    logic [31:0] v;
    int n;
    int fa, fb, ft;

    // Reset state
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", sig_count, 0);
    chk("rst_cycles", cycles, 0);
    rd(0, v); chk("rst_log0", v, 0);
    RST = 1'b0;
    tick();

    // Fibonacci pass
    do_start();
    chk("start_busy", busy, 1);
    for (int i = 0; i < 8; i++) store(10'h100 + 10'(i), 32'(fibs[i]));
    chk("pre_mbox_done", done, 0);
    store(10'h3FF, 1);
    chk("fib_done", done, 1);
    chk("fib_pass", pass, 1);
    chk("fib_cnt", sig_count, 8);
    chk("fib_mism", mismatch, 0);
    chk("fib_exit", exit_code, 1);
    chk("fib_cycles", cycles, 9);
    rd(7, v); chk("fib_log7", v, 13);
    rd(3, v); chk("fib_log3", v, 2);
    tick();
    chk("cycles_frozen", cycles, 9);

    // Bad value at index 5
    do_start();
    for (int i = 0; i < 8; i++) store(10'h100 + 10'(i), 32'(bads[i]));
    store(10'h3FF, 1);
    chk("bad_mism", mismatch, 1);
    chk("bad_idx", first_bad_idx, 5);
    chk("bad_pass", pass, 0);
    chk("bad_done", done, 1);

    // Timeout with no mailbox
    do_start();
    n = 0;
    while (!done && n < 4000) begin tick(); n++; end
    chk("tmo_len", n, 3000);
    chk("tmo_flag", timeout, 1);
    chk("tmo_pass", pass, 0);
    chk("tmo_cycles", cycles, 3000);

    // Mailbox on the timeout cycle wins
    do_start();
    for (int i = 0; i < 2999; i++) tick();
    chk("tmo2_notdone", done, 0);
    store(10'h3FF, 1);
    chk("tmo2_done", done, 1);
    chk("tmo2_flag", timeout, 0);
    chk("tmo2_pass", pass, 1);

    // Overflow: 17 correct window stores
    do_start();
    fa = 0; fb = 1;
    for (int i = 0; i < 17; i++) begin
      store(10'h100 + 10'(i % 16), 32'(fa));
      ft = fa + fb; fa = fb; fb = ft;
    end
    store(10'h3FF, 1);
    chk("ovf_cnt", sig_count, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_mism", mismatch, 0);
    chk("ovf_pass", pass, 0);
    rd(15, v); chk("ovf_log15", v, 610);

    // Restart clears everything
    do_start();
    chk("clr_cnt", sig_count, 0);
    chk("clr_ovf", overflow, 0);
    chk("clr_done", done, 0);
    chk("clr_exit", exit_code, 0);
    chk("clr_cycles", cycles, 0);
    rd(0, v); chk("clr_log0", v, 0);

    // Filtering: outside window and MemWrite=0 are not logged
    store(10'h0FF, 0);
    store(10'h110, 0);
    MemWrite = 1'b0; address_DMEM = 10'h100; write_data_DMEM = 32'h55;
    tick();
    chk("flt_cnt0", sig_count, 0);
    store(10'h10F, 0);
    chk("flt_edge_cnt", sig_count, 1);
    store(10'h3FF, 32'hDEAD);
    chk("flt_exit", exit_code, 32'hDEAD);
    chk("flt_pass", pass, 0);
    chk("flt_mism", mismatch, 0);

    // Reset mid-run
    do_start();
    for (int i = 0; i < 5; i++) store(10'h100 + 10'(i), 32'(fibs[i]));
    chk("mid_cnt", sig_count, 5);
    #2 RST = 1'b1;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_cnt0", sig_count, 0);
    chk("mid_cycles", cycles, 0);
    rd(4, v); chk("mid_log4", v, 0);
    RST = 1'b0;
    store(10'h3FF, 1);
    chk("mid_nodone", done, 0);
    chk("mid_nobusy", busy, 0);
    chk("mid_noexit", exit_code, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
